// File: rtl/ov7670_stream_gen.sv
// OV7670 camera-bus transmitter: pclk/vsync/href plus YUYV 4:2:2 test patterns,
// with OV7670 frame and line sequencing, all from one fabric clock.
module ov7670_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int CW          = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] dout,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    localparam logic [CW-1:0] LINE_LAST  = CW'(2*H_ACTIVE + H_BLANK - 1);
    localparam logic [CW-1:0] ACT_BYTES  = CW'(2*H_ACTIVE);
    localparam logic [CW-1:0] PIX_LAST   = CW'(2*H_ACTIVE - 1);
    localparam logic [CW-1:0] HACT       = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VS_LAST    = CW'(VSYNC_LINES - 1);
    localparam logic [CW-1:0] VB_LAST    = CW'(V_BACK - 1);
    localparam logic [CW-1:0] VA_LAST    = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] VF_LAST    = CW'(V_FRONT - 1);

    state_t          r_state;
    state_t          w_nextState;
    logic            r_pclk;
    logic            r_frameDone;
    logic [CW-1:0]   r_bc;
    logic [CW-1:0]   r_lc;
    logic [1:0]      r_pattern;
    logic [7:0]      r_frameCnt;
    logic [CW-1:0]   r_barAcc;
    logic [2:0]      r_bar;

    logic            w_ue;
    logic            w_lineEnd;
    logic            w_stateDone;
    logic            w_frameEnd;
    logic            w_startFrame;
    logic [CW-1:0]   w_lastLine;
    logic [CW-1:0]   w_barNext;
    logic [CW-1:0]   w_x;
    logic [7:0]      w_y;
    logic [7:0]      w_u;
    logic [7:0]      w_v;

    // Every state-visible register moves only when pclk falls.
    assign w_ue         = r_pclk;
    assign w_lineEnd    = (r_bc == LINE_LAST);
    assign w_stateDone  = w_lineEnd && (r_lc == w_lastLine);
    assign w_startFrame = w_ue && (w_nextState == S_VSYNC) && (r_state != S_VSYNC);
    assign w_barNext    = r_barAcc + CW'(8);
    assign w_x          = r_bc >> 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_frameEnd  = 1'b0;
        w_lastLine  = '0;
        case (r_state)
            S_VSYNC:  w_lastLine = VS_LAST;
            S_VBACK:  w_lastLine = VB_LAST;
            S_ACTIVE: w_lastLine = VA_LAST;
            S_VFRONT: w_lastLine = VF_LAST;
            default:  w_lastLine = '0;
        endcase
        if (w_ue) begin
            case (r_state)
                S_IDLE: begin
                    if (enable) w_nextState = S_VSYNC;
                end
                S_VSYNC: begin
                    if (w_stateDone) w_nextState = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
                end
                S_VBACK: begin
                    if (w_stateDone) w_nextState = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (w_stateDone) begin
                        if (V_FRONT > 0) begin
                            w_nextState = S_VFRONT;
                        end else begin
                            w_frameEnd  = 1'b1;
                            w_nextState = enable ? S_VSYNC : S_IDLE;
                        end
                    end
                end
                S_VFRONT: begin
                    if (w_stateDone) begin
                        w_frameEnd  = 1'b1;
                        w_nextState = enable ? S_VSYNC : S_IDLE;
                    end
                end
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    // Bar index tracks floor(x*8/H_ACTIVE) by accumulating 8 per pixel modulo H_ACTIVE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pclk      <= 1'b0;
            r_frameDone <= 1'b0;
            r_bc        <= '0;
            r_lc        <= '0;
            r_pattern   <= 2'd0;
            r_frameCnt  <= 8'd0;
            r_barAcc    <= '0;
            r_bar       <= 3'd0;
        end else begin
            r_pclk      <= ~r_pclk;
            r_frameDone <= w_frameEnd;
            if (w_ue) begin
                if (w_nextState != r_state) begin
                    r_bc <= '0;
                    r_lc <= '0;
                end else if (r_state != S_IDLE) begin
                    if (w_lineEnd) begin
                        r_bc <= '0;
                        r_lc <= r_lc + CW'(1);
                    end else begin
                        r_bc <= r_bc + CW'(1);
                    end
                end
                if (w_startFrame) r_pattern  <= pattern_sel;
                if (w_frameEnd)   r_frameCnt <= r_frameCnt + 8'd1;
                if ((w_nextState != r_state) || w_lineEnd) begin
                    r_barAcc <= '0;
                    r_bar    <= 3'd0;
                end else if (r_bc[0] && (r_bc < PIX_LAST)) begin
                    if (w_barNext >= HACT) begin
                        r_barAcc <= w_barNext - HACT;
                        r_bar    <= r_bar + 3'd1;
                    end else begin
                        r_barAcc <= w_barNext;
                    end
                end
            end
        end
    end

    always_comb begin
        pclk       = r_pclk;
        frame_done = r_frameDone;
        busy       = (r_state != S_IDLE);
        vsync      = (r_state == S_VSYNC);
        href       = (r_state == S_ACTIVE) && (r_bc < ACT_BYTES);
        w_u        = 8'd128;
        w_v        = 8'd128;
        w_y        = 8'd16;
        case (r_pattern)
            2'd0: begin
                case (r_bar)
                    3'd0:    begin w_y = 8'd235; w_u = 8'd128; w_v = 8'd128; end
                    3'd1:    begin w_y = 8'd210; w_u = 8'd16;  w_v = 8'd146; end
                    3'd2:    begin w_y = 8'd170; w_u = 8'd166; w_v = 8'd16;  end
                    3'd3:    begin w_y = 8'd145; w_u = 8'd54;  w_v = 8'd34;  end
                    3'd4:    begin w_y = 8'd106; w_u = 8'd202; w_v = 8'd222; end
                    3'd5:    begin w_y = 8'd81;  w_u = 8'd90;  w_v = 8'd240; end
                    3'd6:    begin w_y = 8'd41;  w_u = 8'd240; w_v = 8'd110; end
                    default: begin w_y = 8'd16;  w_u = 8'd128; w_v = 8'd128; end
                endcase
            end
            2'd1:    w_y = 8'(w_x + r_lc);
            2'd2:    w_y = r_frameCnt;
            default: w_y = (w_x[3] ^ r_lc[3]) ? 8'd235 : 8'd16;
        endcase
        dout = 8'h00;
        if (href) begin
            if (!r_bc[0])      dout = w_y;
            else if (!w_x[0])  dout = w_u;
            else               dout = w_v;
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Scoreboard bench for ov7670_stream_gen: expected bytes are queued as stimulus is
// issued and popped by a monitor on every href byte; frame timing checked directly.
module tb_ov7670_stream_gen;

    localparam int H_ACTIVE    = 16;
    localparam int H_BLANK     = 4;
    localparam int V_ACTIVE    = 4;
    localparam int VSYNC_LINES = 1;
    localparam int V_BACK      = 1;
    localparam int V_FRONT     = 1;
    localparam int CW          = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] dout;
    logic       frame_done;
    logic       busy;

    ov7670_stream_gen #(
        .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
        .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
        .pclk(pclk), .vsync(vsync), .href(href), .dout(dout),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checkCount = 0;
    int passCount  = 0;
    int expQ[$];
    int violBoth = 0;
    int violDout = 0;
    int monExp;

    int barY[8] = '{235, 210, 170, 145, 106, 81, 41, 16};
    int barU[8] = '{128, 16, 166, 54, 202, 90, 240, 128};
    int barV[8] = '{128, 146, 16, 34, 222, 240, 110, 128};

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic int expY(input int pat, input int fc, input int x, input int y);
        case (pat)
            0:       return barY[(x * 8) / H_ACTIVE];
            1:       return (x + y) % 256;
            2:       return fc % 256;
            default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 235 : 16;
        endcase
    endfunction

    function automatic int expC(input int pat, input int x);
        if (pat != 0) return 128;
        return ((x % 2) == 0) ? barU[(x * 8) / H_ACTIVE] : barV[(x * 8) / H_ACTIVE];
    endfunction

    // Drives pattern_sel and queues the full expected byte stream of one frame.
    task automatic applyStimulus(input int pat, input int fc);
        pattern_sel = 2'(pat);
        for (int y = 0; y < V_ACTIVE; y++) begin
            for (int x = 0; x < H_ACTIVE; x++) begin
                expQ.push_back(expY(pat, fc, x, y));
                expQ.push_back(expC(pat, x));
            end
        end
    endtask

    function automatic logic sigOf(input int sel);
        case (sel)
            0:       return vsync;
            1:       return href;
            2:       return frame_done;
            default: return busy;
        endcase
    endfunction

    task automatic waitSig(input int sel, input logic level, input string name, output int t);
        bit done;
        done = 0;
        t = -1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (sigOf(sel) == level) begin
                t = cyc;
                done = 1;
            end
        end
        if (!done) checkOutput({name, "Timeout"}, 0, 1);
    endtask

    // Monitor: one sample per byte period, taken while pclk is high.
    always @(negedge clk) begin
        if (href && vsync) violBoth++;
        if (!href && dout != 8'h00) violDout++;
        if (pclk && href) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedByte", int'(dout), -1);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("pixelByte", int'(dout), monExp);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tEn, tVs, tVf, tH1, tH1f, tH2, tFd0, tFd1, tFd2, tFd3, tFd4, tTmp;
        int expLat, toggles, quiet, late;
        logic prev;

        repeat (5) @(negedge clk);
        checkOutput("resetPclk", int'(pclk), 0);
        checkOutput("resetVsync", int'(vsync), 0);
        checkOutput("resetHref", int'(href), 0);
        checkOutput("resetDout", int'(dout), 0);
        checkOutput("resetFrameDone", int'(frame_done), 0);
        checkOutput("resetBusy", int'(busy), 0);
        reset = 1'b1;

        prev = pclk;
        toggles = 0;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (pclk != prev) toggles++;
            prev = pclk;
            if (busy || vsync || href || frame_done || dout != 8'h00) quiet++;
        end
        checkOutput("pclkToggles", toggles, 20);
        checkOutput("idleQuiet", quiet, 0);

        // Three flat frames: Y follows the frame counter 0,1,2.
        applyStimulus(2, 0);
        applyStimulus(2, 1);
        applyStimulus(2, 2);
        expLat = pclk ? 1 : 2;
        tEn = cyc;
        enable = 1'b1;
        waitSig(0, 1'b1, "vsyncRise", tVs);
        checkOutput("vsyncLatency", tVs - tEn, expLat);
        checkOutput("busyInFrame", int'(busy), 1);
        waitSig(0, 1'b0, "vsyncFall", tVf);
        checkOutput("vsyncWidth", tVf - tVs, 72);
        waitSig(1, 1'b1, "hrefRise", tH1);
        checkOutput("vbackGap", tH1 - tVf, 72);
        waitSig(1, 1'b0, "hrefFall", tH1f);
        checkOutput("hrefWidth", tH1f - tH1, 64);
        waitSig(1, 1'b1, "hrefRise2", tH2);
        checkOutput("hrefGap", tH2 - tH1f, 8);
        waitSig(2, 1'b1, "frameDone0", tFd0);
        checkOutput("frameLength", tFd0 - tVs, 504);
        checkOutput("vsyncWithDone", int'(vsync), 1);

        waitSig(2, 1'b1, "frameDone1", tFd1);
        checkOutput("framePeriod1", tFd1 - tFd0, 504);

        // Mid-ACTIVE pattern change must wait for the next frame.
        waitSig(1, 1'b1, "hrefFrame2", tTmp);
        applyStimulus(0, 3);
        waitSig(2, 1'b1, "frameDone2", tFd2);
        checkOutput("framePeriod2", tFd2 - tFd1, 504);

        waitSig(1, 1'b1, "hrefFrame3", tTmp);
        applyStimulus(1, 4);
        waitSig(2, 1'b1, "frameDone3", tFd3);
        checkOutput("framePeriod3", tFd3 - tFd2, 504);

        // Drop enable mid-ACTIVE: frame finishes, then the generator idles.
        waitSig(1, 1'b1, "hrefFrame4", tTmp);
        repeat (80) @(negedge clk);
        enable = 1'b0;
        waitSig(2, 1'b1, "frameDone4", tFd4);
        checkOutput("framePeriod4", tFd4 - tFd3, 504);
        checkOutput("busyFallsWithDone", int'(busy), 0);
        checkOutput("noVsyncAfterStop", int'(vsync), 0);
        late = 0;
        repeat (600) begin
            @(negedge clk);
            if (vsync || busy || href) late++;
        end
        checkOutput("idleAfterStop", late, 0);

        // Asynchronous reset in the middle of a checkerboard line.
        applyStimulus(3, 5);
        enable = 1'b1;
        waitSig(1, 1'b1, "hrefCheck", tTmp);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abortHref", int'(href), 0);
        checkOutput("abortDout", int'(dout), 0);
        checkOutput("abortVsync", int'(vsync), 0);
        checkOutput("abortBusy", int'(busy), 0);
        expQ.delete();
        repeat (3) @(negedge clk);
        applyStimulus(2, 0);
        expLat = pclk ? 1 : 2;
        tEn = cyc;
        reset = 1'b1;
        waitSig(0, 1'b1, "vsyncRestart", tVs);
        checkOutput("restartLatency", tVs - tEn, expLat);
        waitSig(1, 1'b1, "hrefRestart", tTmp);
        enable = 1'b0;
        waitSig(2, 1'b1, "frameDoneRestart", tTmp);
        checkOutput("restartFrameLength", tTmp - tVs, 504);
        repeat (20) @(negedge clk);

        checkOutput("queueDrained", expQ.size(), 0);
        checkOutput("hrefVsyncOverlap", violBoth, 0);
        checkOutput("doutOutsideHref", violDout, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ov7670_stream_gen.md
Name: ov7670_stream_gen

Overview:
- Synthesizable OV7670 camera-bus transmitter. Emits `pclk`, `vsync`, `href` and 8-bit YUYV 4:2:2 data with OV7670 frame and line sequencing.
- Drives the camera-side inputs of the YUV capture path in place of the real sensor. Used for bring-up and regression of capture, CDC FIFO and HDMI output without the camera attached.
- Generates test patterns internally from a single fabric clock.

Parameters:
- H_ACTIVE, 640, active pixels per line; must be even, at least 8.
- H_BLANK, 144, `href`-low byte periods after each active line; at least 1.
- V_ACTIVE, 480, active lines per frame; at least 1.
- VSYNC_LINES, 3, lines with `vsync` high; at least 1.
- V_BACK, 17, blank lines after `vsync`, before the first active line; at least 0.
- V_FRONT, 10, blank lines after the last active line; at least 0.
- CW, 12, width of the internal byte/line counters; must hold 2*H_ACTIVE+H_BLANK and every line count.

Ports:
- clk  in  1  fabric clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- enable  in  1  level; frames are generated while high.
- pattern_sel  in  2  0 = colour bars, 1 = luma ramp, 2 = flat frame-count, 3 = checkerboard.
- pclk  out  1  pixel clock, clk/2, free-running.
- vsync  out  1  frame sync, active high.
- href  out  1  line valid, active high.
- dout  out  8  camera data byte.
- frame_done  out  1  one-clk pulse at the end of each frame.
- busy  out  1  high from frame start until return to IDLE.

Behaviour:
- Reset: `pclk`, `vsync`, `href`, `frame_done`, `busy` = 0; `dout` = 0x00; state IDLE; frame counter = 0.
- Reset mid-frame aborts immediately: outputs go to their reset values, with no partial-line completion.
- `pclk`: registered toggle, every clk, including in IDLE.
- Update edge (UE): the clk edge on which `pclk` goes 1 to 0.
  - `vsync`, `href` and `dout` change only on UEs, so they are stable across the `pclk` rising edge.
  - Byte period = 2 clk.
- Byte counter `bc`: 0 to 2*H_ACTIVE+H_BLANK-1, advances each UE.
- Line counter `lc`: increments when `bc` wraps and resets on each state change.
- State machine (transitions only on UE):
  - IDLE: if `enable`=1, latch `pattern_sel`, set `busy`, go to VSYNC. Else stay.
  - VSYNC: `vsync`=1 for VSYNC_LINES lines, then go to VBACK.
  - VBACK: V_BACK lines, then go to ACTIVE. If V_BACK=0, skip this state.
  - ACTIVE: V_ACTIVE lines. `href`=1 while `bc` < 2*H_ACTIVE, else 0. Then go to VFRONT.
  - VFRONT: V_FRONT lines. If V_FRONT=0, skip this state.
  - End of frame: `frame_done`=1 for one clk on the final UE of the frame; frame counter increments (8-bit, wraps 255 to 0).
    - If `enable`=1, go directly to VSYNC: no idle gap, `pattern_sel` re-latched.
    - Else go to IDLE and clear `busy`.
- `enable` deassert mid-frame: the current frame completes in full. `pattern_sel` changes mid-frame are ignored.
- `href` and `vsync` are never high together.
- `dout` is 0x00 whenever `href`=0.
- Byte mapping in ACTIVE with `href`=1, pixel x = `bc`>>1:
  - `bc`[0]=0: Y(x).
  - `bc`[0]=1 and x even: U(x).
  - `bc`[0]=1 and x odd: V(x).
  - Sequence is therefore Y0 U0 Y1 V1 ...
- Line index y = `lc` within ACTIVE.
- Pattern 0, colour bars. Bar index = x*8/H_ACTIVE (integer). (Y,U,V) for bars 0 to 7:
  - 0 white: (235,128,128)
  - 1 yellow: (210,16,146)
  - 2 cyan: (170,166,16)
  - 3 green: (145,54,34)
  - 4 magenta: (106,202,222)
  - 5 red: (81,90,240)
  - 6 blue: (41,240,110)
  - 7 black: (16,128,128)
  - Implement the divide as a bar-boundary counter; no divider.
- Pattern 1, luma ramp: Y = (x+y) mod 256; U = V = 128.
- Pattern 2, flat: Y = frame counter; U = V = 128.
- Pattern 3, checkerboard: Y = 235 if (x[3] XOR y[3]) else 16; U = V = 128.
- Latency: `enable` rising in IDLE gives `vsync` high on the next UE, i.e. 1 to 2 clk later.

Test Plan:
Bench parameters: H_ACTIVE=16, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1. Line = 36 bytes = 72 clk; frame = 7 lines = 504 clk.
- Reset low for 5 clk, then high with `enable`=0 -> all outputs 0, `pclk` toggles every clk, `busy`=0 indefinitely.
- `enable`=1, `pattern_sel`=0 -> `vsync` high exactly 72 clk; first `href` rise 72 clk after `vsync` falls; 4 `href` pulses of 32 bytes each, 8 clk low gap between them; first line bytes 235,128,235,128,210,16,210,146,...; last pair 16,128,16,128.
- Continuous `enable`=1 -> `frame_done` pulses every 504 clk; next `vsync` on the following UE; with `pattern_sel`=2, Y bytes equal 0,1,2 in successive frames.
- `pattern_sel` changed 0 to 1 during the ACTIVE state of frame N -> frame N stays colour bars; frame N+1 line 2 starts Y=2,U=128,Y=3,V=128.
- `enable` dropped mid-ACTIVE -> remaining lines and VFRONT complete; `frame_done` pulses; `busy` falls on the same UE; no further `vsync`.
- Reset asserted mid-line with `href`=1 -> `href`, `dout`, `vsync` = 0 immediately (asynchronous); after release with `enable`=1, the frame restarts from VSYNC with frame count 0.
